// File: rtl/skinny_round_seq_if.sv
// Round-control bundle between the mode controller, the round sequencer and
// the masked SKINNY datapath.
//
// Handshake: rdi_valid/rdi_ready follow strict valid/ready semantics. A
// randomness word transfers on a rising clk edge where both are 1. The
// producer holds rdi_valid (and its word) until the transfer happens. The
// sequencer only raises rdi_ready in its sampling phase, and never makes it
// depend on anything but rdi_valid and its own state.
interface skinny_round_seq_if;
  logic       start;
  logic       tk1_use;
  logic       rdi_valid;
  logic       rdi_ready;
  logic       busy;
  logic       done;
  logic       senc;
  logic       sse;
  logic       xenc;
  logic       xse;
  logic       yenc;
  logic       yse;
  logic       zenc;
  logic       zse;
  logic [5:0] constant;
  logic       tk1s;
  logic [5:0] round;

  // Mode controller / datapath side
  modport master (
    output start, tk1_use, rdi_valid,
    input  rdi_ready, busy, done, senc, sse, xenc, xse, yenc, yse, zenc, zse,
    input  constant, tk1s, round
  );

  // Round sequencer side
  modport slave (
    input  start, tk1_use, rdi_valid,
    output rdi_ready, busy, done, senc, sse, xenc, xse, yenc, yse, zenc, zse,
    output constant, tk1s, round
  );
endinterface

// File: rtl/skinny_round_seq.sv
// Round sequencer for the masked 32-bit Romulus-N datapath. It runs ROUNDS
// SKINNY-128-384+ rounds per call. Each round is ROUND_CYCLES cycles: it
// samples fresh randomness, optionally waits, then commits. The round stalls
// in the sampling phase while no randomness is offered.
module skinny_round_seq #(
  parameter int ROUNDS       = 40,
  parameter int ROUND_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  skinny_round_seq_if.slave   bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [5:0] const_q, const_d;
  logic [5:0] round_q, round_d;
  logic       tk1s_q, tk1s_d;
  logic       done_q, done_d;
  logic       last_round;

  assign last_round = (round_q == 6'(ROUNDS - 1));

  // State and datapath registers; reset returns everything to idle zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 8'd0;
      const_q <= 6'h00;
      round_q <= 6'd0;
      tk1s_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      const_q <= const_d;
      round_q <= round_d;
      tk1s_q  <= tk1s_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; WAIT phases only exist when a round is longer than 2 cycles
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.rdi_valid) begin
          phase_d = 8'd1;
          state_d = (ROUND_CYCLES > 2) ? S_WAIT : S_COMMIT;
        end
      end
      S_WAIT: begin
        if (phase_q == 8'(ROUND_CYCLES - 2)) state_d = S_COMMIT;
        else                                 phase_d = phase_q + 8'd1;
      end
      S_COMMIT: begin
        state_d = last_round ? S_FINISH : S_SAMPLE;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round counter, round-constant LFSR, tk1 select and the done pulse
  always_comb begin
    const_d = const_q;
    round_d = round_q;
    tk1s_d  = tk1s_q;
    done_d  = (state_q == S_FINISH);
    if (state_q == S_IDLE && bus.start) begin
      tk1s_d  = bus.tk1_use;
      const_d = 6'h01;
      round_d = 6'd0;
    end else if (state_q == S_COMMIT && !last_round) begin
      round_d = round_q + 6'd1;
      const_d = {const_q[4:0], const_q[5] ^ const_q[4] ^ 1'b1};
    end else if (state_q == S_FINISH) begin
      tk1s_d = 1'b0;
    end
  end

  // Outputs: enables only in COMMIT, randomness accepted only in SAMPLE
  always_comb begin
    bus.senc      = (state_q == S_COMMIT);
    bus.xenc      = (state_q == S_COMMIT);
    bus.yenc      = (state_q == S_COMMIT);
    bus.zenc      = (state_q == S_COMMIT);
    bus.sse       = 1'b0;
    bus.xse       = 1'b0;
    bus.yse       = 1'b0;
    bus.zse       = 1'b0;
    bus.rdi_ready = (state_q == S_SAMPLE) && bus.rdi_valid;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = done_q;
    bus.constant  = const_q;
    bus.round     = round_q;
    bus.tk1s      = tk1s_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: doc/skinny_round_seq.md
Name: skinny_round_seq

Overview:
- Round sequencer for the masked 32-bit Romulus-N datapath. It drives the round-side controls of the datapath top: state/tweakey register enables, the 6-bit SKINNY round constant and the tk1s select.
- It also runs the valid/ready handshake on fresh randomness for the HPC2 round function, and stalls rounds whenever randomness is missing.
- It sits between the mode-level controller (issues start, consumes done) and the datapath top. Data loading and unloading stay with the mode controller. This block owns only the encryption rounds.

Parameters:
- ROUNDS, 40, number of SKINNY-128-384+ rounds per block call (legal range 1..63).
- ROUND_CYCLES, 2, clock cycles per round. Cycle 0 samples fresh randomness into the HPC2 gadgets; the last cycle commits the round.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle request to run ROUNDS rounds; ignored while busy=1
- tk1_use  input  1  sampled at start; selects whether TK1 (counter) enters the round key
- rdi_valid  input  1  fresh randomness word on rdi is valid this cycle
- rdi_ready  output  1  randomness consumed this cycle
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse after the final round commits
- senc, sse  output  1 each  state register enable / serial-shift select
- xenc, xse, yenc, yse, zenc, zse  output  1 each  TK2/TK1-path/TK3 register enable / shift select
- constant  output  6  SKINNY round constant for the current round
- tk1s  output  1  TK1 insertion select, held for the whole call
- round  output  6  index of the current round, 0..ROUNDS-1

Behaviour:
- Reset (async, rst=1) sets all outputs to 0: constant=6'h00, round=0, FSM=IDLE.
- FSM states: IDLE, SAMPLE, COMMIT (COMMIT is the last of ROUND_CYCLES; with ROUND_CYCLES>2, WAIT phases sit between), FINISH.
- IDLE: on start=1, latch tk1_use into tk1s, set constant=6'h01 and round=0, and go to SAMPLE next cycle. busy goes 1 on that edge.
- SAMPLE: rdi_ready = rdi_valid. If rdi_valid=0, stay in SAMPLE (stall); all enables stay 0 and constant/round are held. If rdi_valid=1, advance.
- COMMIT: assert senc, xenc, yenc, zenc = 1 for exactly one cycle. All se outputs stay 0 throughout rounds. rdi_ready=0.
  - If round == ROUNDS-1, go to FINISH.
  - Otherwise round += 1, constant updates to {c[4:0], c[5]^c[4]^1'b1}, and the FSM returns to SAMPLE.
- FINISH: done=1 for one cycle, busy=0 at the same edge, tk1s cleared to 0, return to IDLE. constant is held at its last value until the next start.
- Latency with no stalls: exactly ROUNDS*ROUND_CYCLES+1 cycles from the start-accepted edge to done (81 for defaults).
- start while busy: ignored, with no effect on counters. start in the FINISH cycle: also ignored.
- No enable is ever asserted outside COMMIT. rdi_ready is asserted only in SAMPLE.
- Reset mid-call: immediate return to IDLE with all outputs 0. No done pulse.
- round never wraps; the ROUNDS-1 compare terminates the call.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0, busy=0 for 20 cycles.
- Nominal call with rdi_valid tied 1 and defaults: the first 8 constant values are 01,03,07,0F,1F,3E,3D,3B. senc pulses exactly 40 times, 2 cycles apart. done appears 81 cycles after start, busy falls with it.
- Randomness stall: drop rdi_valid for 5 cycles during SAMPLE of round 3 -> rdi_ready=0, no enables, constant=0x0F and round=3 held. Total latency becomes 86.
- tk1_use=1 at start -> tk1s=1 from the next cycle until done, then 0. A second call with tk1_use=0 keeps tk1s=0 throughout.
- start re-pulsed at round 10 and in the FINISH cycle -> ignored; exactly one done pulse per accepted start.
- Async rst asserted at round 20 mid-COMMIT -> outputs 0 immediately. A fresh start then yields constant 01 and the full 81-cycle latency.
